ecc_mod_alu: RTL and testbench

Parametrised, multi-mode modular arithmetic unit for the ECC datapath. It computes modular multiply, square, add and subtract over a run-time prime using a start/done handshake. It is the next-generation replacement for the fixed 256-bit multiply path of `ECC_core`. Multiply and square use a radix-2 interleaved shift-add-reduce loop. Operand range errors are detected and reported rather than silently producing garbage.

---
 rtl/ecc_mod_pkg.sv | 5 +
 rtl/mod_cond_sub.sv | 10 +
 rtl/ecc_mod_alu.sv | 75 +++++++
 tb/tb_ecc_mod_alu.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ecc_mod_pkg.sv
// ecc_mod_pkg: shared op and state encodings for the modular ALU
package ecc_mod_pkg;
  typedef enum logic [1:0] {MUL = 2'b00, SQR = 2'b01, ADD = 2'b10, SUB = 2'b11} mod_op_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mod_state_e;
endpackage

// File: rtl/mod_cond_sub.sv
// mod_cond_sub: single conditional subtraction of p from a WIDTH+1-bit value
module mod_cond_sub #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH:0]   x,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] y
);
  assign y = x >= {1'b0, p} ? WIDTH'(x - {1'b0, p}) : x[WIDTH-1:0];
endmodule

// File: rtl/ecc_mod_alu.sv
// ecc_mod_alu: run-time-prime modular MUL/SQR/ADD/SUB with start/done handshake
module ecc_mod_alu
  import ecc_mod_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] prime,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);
  mod_state_e state, state_nx;
  mod_op_e op_r, op_in;
  logic [WIDTH-1:0] a_r, b_r, p_r, acc, s1, s2, mpl, sub_v;
  logic [CNT_W-1:0] idx;
  logic [WIDTH:0] x2;
  logic accept, bad, last, bit_v;
  assign op_in  = mod_op_e'(mode);
  assign accept = state == IDLE && start;
  assign bad    = prime[WIDTH-1:1] == '0 || a >= prime || (b >= prime && op_in != SQR);
  assign mpl    = op_r == SQR ? a_r : b_r;
  assign bit_v  = mpl[idx];
  assign last   = op_r == ADD || op_r == SUB || idx == '0;
  // first correction doubles acc; second either adds the multiplicand or forms a+b
  mod_cond_sub #(.WIDTH(WIDTH)) u_dbl (.x({acc, 1'b0}), .p(p_r), .y(s1));
  assign x2 = op_r == ADD ? {1'b0, a_r} + {1'b0, b_r} : {1'b0, s1} + {1'b0, bit_v ? a_r : '0};
  mod_cond_sub #(.WIDTH(WIDTH)) u_add (.x(x2), .p(p_r), .y(s2));
  assign sub_v = a_r - b_r + (a_r >= b_r ? '0 : p_r);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (bad ? DONE : RUN) : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge i_clk)
    if (accept) begin
      a_r  <= a;
      b_r  <= b;
      p_r  <= prime;
      op_r <= op_in;
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      acc    <= '0;
      idx    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      acc    <= '0;
      idx    <= CNT_W'(WIDTH - 1);
      result <= '0;
      err    <= bad;
    end else if (state == RUN) begin
      acc <= s2;
      idx <= idx - 1'b1;
      if (last) result <= op_r == SUB ? sub_v : s2;
    end
endmodule

// File: tb/tb_ecc_mod_alu.sv
// tb_ecc_mod_alu: scoreboard bench for 256-bit and 8-bit instances of ecc_mod_alu
module tb_ecc_mod_alu;
  typedef struct {
    logic [255:0] r;
    logic         e;
    int           lat;
  } exp_t;

  logic clk = 0, rst_n = 0;
  logic start = 0, start8 = 0;
  logic [1:0] mode = 0, mode8 = 0;
  logic [255:0] a = 0, b = 0, p = 0, result;
  logic [7:0] a8 = 0, b8 = 0, p8 = 0, result8;
  logic busy, done, err, busy8, done8, err8;
  exp_t q[$], q8[$];
  int checks = 0, errors = 0, cyc = 0;

  ecc_mod_alu #(.WIDTH(256)) dut (.i_clk(clk), .i_rst_n(rst_n), .start(start), .mode(mode),
    .a(a), .b(b), .prime(p), .busy(busy), .done(done), .err(err), .result(result));
  ecc_mod_alu #(.WIDTH(8)) dut8 (.i_clk(clk), .i_rst_n(rst_n), .start(start8), .mode(mode8),
    .a(a8), .b(b8), .prime(p8), .busy(busy8), .done(done8), .err(err8), .result(result8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [255:0] act, input logic [255:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, want);
    end
  endtask

  int acc_c = 0, last_d = 0, acc_c8 = 0;
  bit held = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && start && !busy && !done) begin
      if (held) check("b2b_gap", 256'(cyc + 1 - last_d), 256'd2);
      held  = 0;
      acc_c = cyc + 1;
    end
    if (done) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done want none");
      end else begin
        e = q.pop_front();
        check("result", result, e.r);
        check("err", 256'(err), 256'(e.e));
        check("latency", 256'(cyc - acc_c + 1), 256'(e.lat));
        check("busy_at_done", 256'(busy), 256'd0);
      end
      last_d = cyc;
      held   = start;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && start8 && !busy8 && !done8) acc_c8 = cyc + 1;
    if (done8) begin
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done8: got done want none");
      end else begin
        e = q8.pop_front();
        check("result8", 256'(result8), e.r);
        check("err8", 256'(err8), 256'(e.e));
        check("latency8", 256'(cyc - acc_c8 + 1), 256'(e.lat));
        check("busy8_at_done", 256'(busy8), 256'd0);
      end
    end
  end

  task automatic wait_empty(input bit w8);
    for (int i = 0; i < 400 && (w8 ? q8.size() : q.size()) != 0; i++) @(posedge clk);
    if ((w8 ? q8.size() : q.size()) != 0) begin
      errors++;
      $display("FAIL timeout: got %0d pending want 0", w8 ? q8.size() : q.size());
      if (w8) q8.delete(); else q.delete();
    end
    #1;
  endtask

  task automatic op(input logic [1:0] m, input logic [255:0] ia, ib, ip, er, input logic ee, input int lat);
    exp_t e;
    e.r = er; e.e = ee; e.lat = lat;
    q.push_back(e);
    mode = m; a = ia; b = ib; p = ip; start = 1;
    @(posedge clk) #1 start = 0;
    wait_empty(0);
  endtask

  task automatic op8(input logic [1:0] m, input logic [7:0] ia, ib, ip, er, input int lat);
    exp_t e;
    e.r = 256'(er); e.e = 0; e.lat = lat;
    q8.push_back(e);
    mode8 = m; a8 = ia; b8 = ib; p8 = ip; start8 = 1;
    @(posedge clk) #1 start8 = 0;
    wait_empty(1);
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < 400 && q.size() != n; i++) @(posedge clk);
    if (q.size() != n) begin
      errors++;
      $display("FAIL timeout_held: got %0d pending want %0d", q.size(), n);
    end
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 256'(busy), 0);
    check("rst_done", 256'(done), 0);
    check("rst_err", 256'(err), 0);
    check("rst_result", result, 0);
    check("rst_result8", 256'(result8), 0);
    rst_n = 1;
    @(posedge clk) #1;
    op(2'b00, 1009, 2003, 7919, 256'h692, 0, 257);
    op(2'b01, 3001, 256'hFFFF, 7919, 256'h832, 0, 257);
    op(2'b10, 7001, 7907, 7919, 256'h1B4D, 0, 2);
    op(2'b11, 1009, 2003, 7919, 256'h1B0D, 0, 2);
    op(2'b00, 7919, 5, 7919, 0, 1, 1);
    op(2'b10, 0, 0, 1, 0, 1, 1);
    op(2'b00, 5, 8000, 7919, 0, 1, 1);
    op(2'b01, 3001, 9000, 7919, 256'h832, 0, 257);
    // start held across three MUL ops; operands change after each accept
    e.e = 0; e.lat = 257;
    e.r = 256'h692; q.push_back(e);
    e.r = 256'h705; q.push_back(e);
    e.r = 256'h1A0; q.push_back(e);
    mode = 2'b00; a = 1009; b = 2003; p = 7919; start = 1;
    @(posedge clk) #1 a = 3001; b = 4001;
    wait_q(2);
    @(posedge clk) #1 a = 5003; b = 6007;
    wait_q(1);
    @(posedge clk) #1 start = 0; a = 0; b = 0;
    wait_empty(0);
    // abort mid-RUN at idx=100 with async reset
    mode = 2'b00; a = 1009; b = 2003; p = 7919; start = 1;
    @(posedge clk) #1 start = 0;
    repeat (155) @(posedge clk);
    #1 check("busy_mid_run", 256'(busy), 1);
    #1 rst_n = 0;
    #1;
    check("arst_busy", 256'(busy), 0);
    check("arst_done", 256'(done), 0);
    check("arst_err", 256'(err), 0);
    check("arst_result", result, 0);
    @(posedge clk) #1 rst_n = 1;
    @(posedge clk) #1;
    op(2'b00, 4003, 5009, 7919, 256'h77, 0, 257);
    op8(2'b00, 250, 250, 251, 1, 9);
    op8(2'b11, 0, 250, 251, 1, 2);
    op8(2'b10, 250, 250, 251, 249, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
